alu_dp_ctrl: RTL
================

# alu_dp_ctrl

Datapath controller that sits directly upstream of the 64-bit ALU and drives its A, B, fsec and carry inputs. It accepts ALU instructions over a valid/ready handshake and reads operands from an 8×64 register file. It captures the ALU's fout, writes the result back, and maintains Z/N/C status flags. The C flag feeds the ALU carry input for add-with-carry.

## Interface
- NREGS, 8, register-file depth; the address width is log2(NREGS) = 3.
- WIDTH, 64, datapath width; must match the ALU.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction valid.
- in_ready  out  1  equals (state==IDLE && !ld_en && !rst).
- in_fsec  in  5  ALU opcode.
- in_dst  in  3  destination register.
- in_srca  in  3  source register for A.
- in_srcb  in  3  source register for B.
- ld_en  in  1  direct register load; honoured only in IDLE.
- ld_addr  in  3  load address.
- ld_data  in  64  load data.
- alu_a  out  64  ALU operand A (registered).
- alu_b  out  64  ALU operand B (registered).
- alu_fsec  out  5  ALU opcode (registered).
- alu_carry  out  1  ALU carry input (registered).
- alu_fout  in  64  ALU result.
- res_valid  out  1  one-cycle pulse at writeback.
- res_data  out  64  written result.
- flags  out  3  {Z,N,C}.
- err  out  1  one-cycle pulse on an illegal opcode.

## Operation
- FSM states are IDLE → READ → EXEC → WB → IDLE.
- IDLE:
  - ld_en writes ld_data to the register file at ld_addr; ld_en has priority over in_valid.
  - An accept (in_valid && in_ready) latches fsec, dst, srca and srcb, then moves to READ.
- READ: alu_a←R[srca], alu_b←R[srcb], alu_fsec←fsec, alu_carry←C.
- EXEC: result register ← alu_fout.
- WB:
  - R[dst] ← result; res_valid=1; res_data=result.
  - Flag update:
    - Z = (result==0).
    - N = result[63].
    - C on fsec 00010: result <u alu_a.
    - C on fsec 00011: (result <u alu_a) | (alu_carry & result==alu_a).
    - C on fsec 00100: alu_a == all-ones.
    - C on any other opcode: unchanged.
- Illegal opcode (fsec ≥ 5'b10001):
  - The instruction is still accepted and sequenced.
  - In WB there is no register write, no flag update and res_valid=0; err=1 instead.
- Register R0 is an ordinary register (not hardwired to zero).
- ld_en outside IDLE is ignored (dropped, not queued).

## Timing
- Occupancy: accept at T; READ at T+1; EXEC at T+2; WB at T+3; in_ready high again at T+4.
- The write commits on the T+3 edge, so an instruction accepted at T+4 sees the new value. There is no hazard logic.
- Throughput is one instruction per 4 cycles.
- rst (any state, including mid-instruction):
  - Next cycle: state=IDLE; all registers and the register file are 0.
  - alu_a, alu_b, alu_fsec, alu_carry = 0.
  - res_valid, res_data, err = 0; flags = 3'b000.
  - in_ready=0 while rst is high.
- ld_en and in_valid both high in IDLE: the load executes, in_ready=0, and the instruction waits.
- in_valid may drop without an accept; there is no side effect.

## Configuration
- ALU_DP_FLAGS_EN defined: Z/N/C flag logic is present, and alu_carry is driven from C.
- ALU_DP_FLAGS_EN undefined:
  - The flags register is removed; flags is tied to 0 and alu_carry to 0.
  - fsec 00011 therefore behaves as A+B.
  - All other behaviour and timing are unchanged.

## Structure
- Package alu_dp_pkg holds:
  - Localparams for all 17 fsec codes (00000–10000) and FSEC_MAX=5'b10000.
  - The state enum {IDLE, READ, EXEC, WB}.
  - The flag bit indices.
- Sub-module alu_dp_regfile: NREGS×WIDTH, two combinational read ports, one synchronous write port, synchronous clear on rst.
- The ALU itself is instantiated alongside at the top level, not inside this block.

## Test plan
- Sub: load R1=5, R2=3; issue fsec 00110, srca=1, srcb=2, dst=3 → res_valid at T+3, R3=2, flags Z=0, N=0, C=0.
- Add overflow: R1=64'hFFFF_FFFF_FFFF_FFFF, R2=1, fsec 00010 → result 0, Z=1, C=1. Then fsec 00011 with R0=0, R0=0 → result 1, C=0.
- Illegal opcode: fsec 10001 → err pulse at T+3, no res_valid, dst unchanged, flags unchanged.
- Reset mid-op: assert rst during EXEC → next cycle state IDLE, res_valid never pulses, R[*]=0, in_ready=1 once rst is low.
- Priority: ld_en and in_valid high together in IDLE → load written, in_ready=0; instruction accepted next cycle.
- Back-to-back dependency: in_valid held high; op1 writes R4 = A+1 from R4=7; op2 reads R4 → accepted at T+4, sees 8.

Source files
------------

// File: rtl/alu_dp_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the ALU datapath controller.
package alu_dp_pkg;

  localparam logic [4:0] FSEC_OP00 = 5'b00000;
  localparam logic [4:0] FSEC_OP01 = 5'b00001;
  localparam logic [4:0] FSEC_OP02 = 5'b00010;
  localparam logic [4:0] FSEC_OP03 = 5'b00011;
  localparam logic [4:0] FSEC_OP04 = 5'b00100;
  localparam logic [4:0] FSEC_OP05 = 5'b00101;
  localparam logic [4:0] FSEC_OP06 = 5'b00110;
  localparam logic [4:0] FSEC_OP07 = 5'b00111;
  localparam logic [4:0] FSEC_OP08 = 5'b01000;
  localparam logic [4:0] FSEC_OP09 = 5'b01001;
  localparam logic [4:0] FSEC_OP10 = 5'b01010;
  localparam logic [4:0] FSEC_OP11 = 5'b01011;
  localparam logic [4:0] FSEC_OP12 = 5'b01100;
  localparam logic [4:0] FSEC_OP13 = 5'b01101;
  localparam logic [4:0] FSEC_OP14 = 5'b01110;
  localparam logic [4:0] FSEC_OP15 = 5'b01111;
  localparam logic [4:0] FSEC_OP16 = 5'b10000;
  localparam logic [4:0] FSEC_MAX  = 5'b10000;

  // Opcodes whose carry-out the controller reconstructs from result and A.
  localparam logic [4:0] FSEC_ADD = FSEC_OP02;
  localparam logic [4:0] FSEC_ADC = FSEC_OP03;
  localparam logic [4:0] FSEC_INC = FSEC_OP04;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  function automatic logic fsec_legal(input logic [4:0] fsec);
    return fsec <= FSEC_MAX;
  endfunction

endpackage

// File: rtl/alu_dp_regfile.sv
// Operand register file: two combinational read ports, one synchronous write port, cleared by rst.
module alu_dp_regfile #(
  parameter int NREGS = 8,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_dp_ctrl.sv
// Sequences ALU instructions IDLE->READ->EXEC->WB around an external 64-bit ALU.
// Define ALU_DP_FLAGS_EN to build the Z/N/C flag register and carry feedback.
module alu_dp_ctrl
  import alu_dp_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_fsec,
  input  logic [AW-1:0]    in_dst,
  input  logic [AW-1:0]    in_srca,
  input  logic [AW-1:0]    in_srcb,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_fsec,
  output logic             alu_carry,
  input  logic [WIDTH-1:0] alu_fout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       flags,
  output logic             err
);

  state_t state, state_next;
  logic [4:0]       fsec_q;
  logic [AW-1:0]    dst_q, srca_q, srcb_q;
  logic [WIDTH-1:0] result_q, rd_a, rd_b;
  logic             accept, legal, carry_src;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  assign in_ready = (state == IDLE) && !ld_en && !rst;
  assign accept   = in_valid && in_ready;
  assign legal    = fsec_legal(fsec_q);

  // A direct load and a writeback never coincide because they live in different states.
  assign rf_we    = ((state == IDLE) && ld_en) || ((state == WB) && legal);
  assign rf_waddr = (state == IDLE) ? ld_addr : dst_q;
  assign rf_wdata = (state == IDLE) ? ld_data : result_q;

  alu_dp_regfile #(.NREGS(NREGS), .WIDTH(WIDTH), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (srca_q),
    .rdata_a (rd_a),
    .raddr_b (srcb_q),
    .rdata_b (rd_b)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fsec_q    <= '0;
      dst_q     <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fsec  <= '0;
      alu_carry <= 1'b0;
      result_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          fsec_q <= in_fsec;
          dst_q  <= in_dst;
          srca_q <= in_srca;
          srcb_q <= in_srcb;
        end
        READ: begin
          alu_a     <= rd_a;
          alu_b     <= rd_b;
          alu_fsec  <= fsec_q;
          alu_carry <= carry_src;
        end
        EXEC:    result_q <= alu_fout;
        default: ;
      endcase
    end
  end

  assign res_valid = (state == WB) && legal;
  assign err       = (state == WB) && !legal;
  assign res_data  = result_q;

`ifdef ALU_DP_FLAGS_EN
  logic [2:0] flags_q;
  logic       c_next;

  // alu_a is still held from READ during WB, so carry-out is rebuilt from result vs. A.
  always_comb begin
    c_next = flags_q[FLAG_C];
    case (fsec_q)
      FSEC_ADD: c_next = result_q < alu_a;
      FSEC_ADC: c_next = (result_q < alu_a) | (alu_carry & (result_q == alu_a));
      FSEC_INC: c_next = &alu_a;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if ((state == WB) && legal) begin
      flags_q[FLAG_Z] <= (result_q == '0);
      flags_q[FLAG_N] <= result_q[WIDTH-1];
      flags_q[FLAG_C] <= c_next;
    end
  end

  assign flags     = flags_q;
  assign carry_src = flags_q[FLAG_C];
`else
  assign flags     = 3'b000;
  assign carry_src = 1'b0;
`endif

endmodule
